// File: rtl/panda_risc_v_dsptc_pkg.sv
// panda_risc_v_dsptc_pkg: shared constants for the dispatch queue (EU channel indices, payload layout)
package panda_risc_v_dsptc_pkg;
  localparam int EU_ALU = 0;
  localparam int EU_BCU = 1;
  localparam int EU_LSU = 2;
  localparam int EU_CSR = 3;
  localparam int EU_MUL = 4;
  localparam int EU_DIV = 5;
  localparam int DEFAULT_EU_N = 6;
  localparam int DEFAULT_PAYLOAD_W = 167;
  localparam int PL_STORE_DIN_LSB = 0;
  localparam int PL_PC_JUMP_LSB = 32;
  localparam int PL_PC_OF_INST_LSB = 64;
  localparam int PL_MSG_REUSED_LSB = 96;
  localparam int PL_MSG_REUSED_W = 71;
endpackage

// File: rtl/panda_risc_v_dsptc_fifo_mem.sv
// panda_risc_v_dsptc_fifo_mem: circular storage with wrap-bit pointers and occupancy/full/empty
// Ports: clk, rst_n (async low), clr (sync clear), push/din write, pop read, dout = head entry.
module panda_risc_v_dsptc_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ptr_one = 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ptr_one;
      if (pop) rptr <= rptr + ptr_one;
    end
  always_ff @(posedge clk)
    if (push && !clr) mem[wptr[AW-1:0]] <= din;
  assign dout = mem[rptr[AW-1:0]];
  assign occupancy = wptr - rptr;
  assign full = occupancy == (AW+1)'(DEPTH);
  assign empty = occupancy == '0;
endmodule

// File: rtl/panda_risc_v_dsptc_queue.sv
// panda_risc_v_dsptc_queue: in-order dispatch buffer issuing the head to one of EU_N execution units
// Ports: s_dispatch_req_* enqueue side, raw_dpc_check_rd_id/rd_raw_dpc WAW check on the head,
// m_eu_* per-channel issue (shared payload/rd_id, one-hot valid), occupancy/empty/full status.
module panda_risc_v_dsptc_queue
  import panda_risc_v_dsptc_pkg::*;
#(
  parameter real simulation_delay = 1,
  parameter int  DEPTH = 4,
  parameter int  EU_N = DEFAULT_EU_N,
  parameter int  PAYLOAD_W = DEFAULT_PAYLOAD_W
) (
  input  logic                   clk,
  input  logic                   sys_resetn,
  input  logic                   sys_reset_req,
  input  logic                   flush_req,
  input  logic [PAYLOAD_W-1:0]   s_dispatch_req_payload,
  input  logic [EU_N-1:0]        s_dispatch_req_eu_sel,
  input  logic [4:0]             s_dispatch_req_rd_id,
  input  logic                   s_dispatch_req_rd_vld,
  input  logic                   s_dispatch_req_valid,
  output logic                   s_dispatch_req_ready,
  output logic [4:0]             raw_dpc_check_rd_id,
  input  logic                   rd_raw_dpc,
  output logic [PAYLOAD_W-1:0]   m_eu_payload,
  output logic [4:0]             m_eu_rd_id,
  output logic [EU_N-1:0]        m_eu_valid,
  input  logic [EU_N-1:0]        m_eu_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   empty,
  output logic                   full
);
  localparam int SW = PAYLOAD_W + EU_N + 6;
  if (simulation_delay < 0.0 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("panda_risc_v_dsptc_queue: illegal parameter value");
  end
  logic clr, push, pop, drop, haz, head_rd_vld;
  logic [EU_N-1:0] sel_1h, head_sel;
  logic [PAYLOAD_W-1:0] head_payload;
  logic [4:0] head_rd;
  logic [SW-1:0] head;
  assign clr = flush_req | sys_reset_req;
  // x & -x isolates the lowest set bit, so a multi-hot select is stored as one-hot
  assign sel_1h = s_dispatch_req_eu_sel & (-s_dispatch_req_eu_sel);
  assign s_dispatch_req_ready = !full && !clr;
  assign push = s_dispatch_req_valid && s_dispatch_req_ready;
  panda_risc_v_dsptc_fifo_mem #(.DEPTH(DEPTH), .WIDTH(SW)) u_fifo (
    .clk(clk),
    .rst_n(sys_resetn),
    .clr(clr),
    .push(push),
    .pop(pop),
    .din({s_dispatch_req_payload, sel_1h, s_dispatch_req_rd_id, s_dispatch_req_rd_vld}),
    .dout(head),
    .occupancy(occupancy),
    .full(full),
    .empty(empty)
  );
  assign {head_payload, head_sel, head_rd, head_rd_vld} = head;
  assign haz = head_rd_vld && rd_raw_dpc;
  assign m_eu_valid = head_sel & {EU_N{!empty && !haz && !clr}};
  // an entry with no target unit would block the queue forever, so it retires on its own
  assign drop = !empty && !clr && (head_sel == '0);
  assign pop = drop || |(m_eu_valid & m_eu_ready);
  assign raw_dpc_check_rd_id = empty ? 5'd0 : head_rd;
  assign m_eu_rd_id = head_rd;
  assign m_eu_payload = head_payload;
endmodule

// File: doc/panda_risc_v_dsptc_queue.md
# panda_risc_v_dsptc_queue

Parametrised dispatch buffer between the dispatch-message generator and the execution units. It holds up to DEPTH decoded instructions in order and issues the head to exactly one of EU_N execution-unit channels. Issue stalls on a WAW hazard on RD or when the target unit is not ready. It decouples decode from EU back-pressure, which the single-slot dispatcher cannot do, and supports flush and system reset at any point.

## Interface
- simulation_delay, 1, real; delay applied to register updates in simulation only
- DEPTH, 4, queue entries; power of 2, range 2..16
- EU_N, 6, number of execution-unit channels
- PAYLOAD_W, 167, opaque per-instruction payload width: {msg_reused[70:0], pc_of_inst, pc_jump, store_din}
- clk  in  1  clock
- sys_resetn  in  1  reset, asynchronous, active-low
- sys_reset_req  in  1  synchronous system-reset request; clears the queue
- flush_req  in  1  synchronous flush request; clears the queue
- s_dispatch_req_payload  in  PAYLOAD_W  instruction payload
- s_dispatch_req_eu_sel  in  EU_N  target EU, one-hot
- s_dispatch_req_rd_id  in  5  RD index
- s_dispatch_req_rd_vld  in  1  instruction writes RD
- s_dispatch_req_valid  in  1  enqueue request
- s_dispatch_req_ready  out  1  enqueue accept
- raw_dpc_check_rd_id  out  5  head RD index, for the WAW check
- rd_raw_dpc  in  1  head RD conflicts with an outstanding long instruction
- m_eu_payload  out  PAYLOAD_W  head payload, shared by all channels
- m_eu_rd_id  out  5  head RD index
- m_eu_valid  out  EU_N  per-channel issue valid
- m_eu_ready  in  EU_N  per-channel issue ready
- occupancy  out  $clog2(DEPTH)+1  current entry count
- empty  out  1  occupancy == 0
- full  out  1  occupancy == DEPTH

## Operation
- Circular buffer with read and write pointers of $clog2(DEPTH)+1 bits each. The extra MSB distinguishes full from empty on wrap-around.
- **Enqueue**
  - s_dispatch_req_ready = !full & !flush_req & !sys_reset_req.
  - A push is a cycle with s_dispatch_req_valid & s_dispatch_req_ready.
  - A push writes the entry at the write pointer. The write pointer increments and wraps DEPTH-1 -> 0.
- **Head selection**
  - eu_sel is resolved at enqueue. For a multi-hot value, the lowest set bit wins, and the stored eu_sel is one-hot or zero.
- **Hazard**
  - haz = head_rd_vld & rd_raw_dpc.
  - raw_dpc_check_rd_id = head rd_id when !empty, else 5'd0.
- **Issue**
  - m_eu_valid[k] = !empty & eu_sel[k] & !haz & !flush_req & !sys_reset_req.
  - Valid does not depend on m_eu_ready[k] (AXIS rule).
  - A pop occurs when m_eu_valid[k] & m_eu_ready[k] for some k.
- **Zero eu_sel entry**
  - The entry is dropped when at the head, unconditionally (no hazard check), in one cycle, with no m_eu_valid asserted.
- **Push and pop**
  - Push and pop in the same cycle leave occupancy unchanged.
  - A push into an empty queue is not visible at the head until the next cycle; there is no pass-through.
- **Flush / sys_reset_req**
  - Either request, same cycle: ready=0 and all m_eu_valid=0.
  - Next edge: both pointers := 0 and occupancy := 0. Entries are discarded.
  - sys_reset_req and flush_req are equivalent in this block.
- Payload, rd_id and rd_vld are passed through unmodified.

## Timing
- Reset (sys_resetn=0) values:
  - pointers and occupancy = 0, empty=1, full=0
  - m_eu_valid=0, raw_dpc_check_rd_id=0
  - s_dispatch_req_ready=1 once sys_resetn=1 and no request is asserted
- Latency from push to m_eu_valid: 1 cycle (registered storage).
- Throughput: 1 issue per cycle when there are no stalls.
- The head holds stable (payload, rd_id, eu_sel) while m_eu_valid is asserted without ready, or while a hazard stall is in progress.
- Full: ready=0. A pop in that cycle does not re-enable ready until the next cycle.
- Flush takes priority over a simultaneous push or pop; neither takes effect.
- rd_raw_dpc rising while the head is valid drops m_eu_valid in the same cycle; that cycle issues nothing.
- Reset asserted mid-operation: all state is cleared asynchronously.

## Structure
- Package panda_risc_v_dsptc_pkg:
  - EU index constants: EU_ALU=0, EU_BCU=1, EU_LSU=2, EU_CSR=3, EU_MUL=4, EU_DIV=5
  - default PAYLOAD_W=167
  - payload field offsets
- Sub-module panda_risc_v_dsptc_fifo_mem, parametrised by DEPTH and width: storage array, pointers, occupancy/full/empty. The top-level module adds the hazard and channel-routing logic.

## Test plan
- **Reset to full:** reset, then 4 pushes to EU_ALU with all m_eu_ready=0 -> occupancy 4, full=1, s_dispatch_req_ready=0, m_eu_valid=6'b000001 with the first payload.
- **Streaming:** 8 back-to-back pushes alternating EU_LSU/EU_MUL, all ready=1 -> 8 issues in order, one per cycle, starting 1 cycle after the first push; occupancy never exceeds 1.
- **WAW stall:** head rd_vld=1, rd_id=5'd7, rd_raw_dpc=1 for 3 cycles -> raw_dpc_check_rd_id=7, m_eu_valid=0 for 3 cycles, issue on the 4th. A repeat with rd_vld=0 -> no stall.
- **Flush:** 3 entries queued plus a push in the same cycle as flush_req -> no issue that cycle, the push is ignored, empty=1 next cycle.
- **Illegal eu_sel:** push 6'b000000 then 6'b010100 -> first entry dropped with no valid; second issues on m_eu_valid=6'b000100.
- **Wrap-around:** DEPTH=4, 10 pushes interleaved with pops -> pointers wrap; issue order and payloads match push order.
